// File: rtl/wb_dmem_slave.sv
// rtl/wb_dmem_slave.sv - Wishbone data-memory slave; incrementing/wrapping bursts only with WB_DMEM_BURST_EN defined
module wb_dmem_slave #(
    parameter int DEPTH = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CLASSIC = 2'd1;
    localparam logic [1:0] ST_ERROR   = 2'd3;
`ifdef WB_DMEM_BURST_EN
    localparam logic [1:0] ST_BURST   = 2'd2;
`endif

    logic [1:0]    state;
    logic [31:0]   mem [DEPTH];
    logic          req;
    logic          in_range;
    logic [AW-1:0] word;
    logic          burst_start;
    logic          mem_we;
    logic [AW-1:0] mem_addr;

    assign req      = wb_cyc_i & wb_stb_i;
    assign in_range = (wb_adr_i[27:AW+2] == '0);
    assign word     = wb_adr_i[AW+1:2];
    assign wb_rty_o = 1'b0;

`ifdef WB_DMEM_BURST_EN
    logic [AW-1:0] beat_addr;
    logic [AW-1:0] next_addr;
    logic          unused_adr;

    assign unused_adr  = ^{wb_adr_i[31:28], wb_adr_i[1:0]};
    assign burst_start = (wb_cti_i == 3'b010);

    // Wrapping bursts only advance the low bits; the aligned block base stays fixed.
    always_comb begin
        next_addr = beat_addr;
        case (wb_bte_i)
            2'b01:   next_addr[1:0] = beat_addr[1:0] + 2'd1;
            2'b10:   next_addr[2:0] = beat_addr[2:0] + 3'd1;
            2'b11:   next_addr[3:0] = beat_addr[3:0] + 4'd1;
            default: next_addr      = beat_addr + 1'b1;
        endcase
    end
`else
    logic unused_in;

    assign unused_in   = ^{wb_adr_i[31:28], wb_adr_i[1:0], wb_cti_i, wb_bte_i};
    assign burst_start = 1'b0;
`endif

    // Classic writes land on the edge that raises ack; burst beats on each stb & ack edge.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = word;
        case (state)
            ST_IDLE:  mem_we = req & in_range & wb_we_i & ~burst_start;
`ifdef WB_DMEM_BURST_EN
            ST_BURST: begin
                mem_we   = req & wb_ack_o & wb_we_i;
                mem_addr = beat_addr;
            end
`endif
            default:  mem_we = 1'b0;
        endcase
        if (wb_rst_i) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        for (int n = 0; n < 4; n++) begin
            if (mem_we && wb_sel_i[n]) begin
                mem[mem_addr][8*n +: 8] <= wb_dat_i[8*n +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= ST_IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'd0;
`ifdef WB_DMEM_BURST_EN
            beat_addr <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (!in_range) begin
                            state    <= ST_ERROR;
                            wb_err_o <= 1'b1;
                        end else begin
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= mem[word];
`ifdef WB_DMEM_BURST_EN
                            beat_addr <= word;
                            state     <= burst_start ? ST_BURST : ST_CLASSIC;
`else
                            state     <= ST_CLASSIC;
`endif
                        end
                    end
                end
`ifdef WB_DMEM_BURST_EN
                ST_BURST: begin
                    // Prefetch the following beat so read data never bubbles.
                    if (req && wb_cti_i != 3'b111) begin
                        beat_addr <= next_addr;
                        wb_dat_o  <= mem[next_addr];
                    end else begin
                        state    <= ST_IDLE;
                        wb_ack_o <= 1'b0;
                    end
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    wb_ack_o <= 1'b0;
                    wb_err_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
